systolic_feeder: RTL and testbench

Upstream stage of the 4x4 output-stationary systolic array. It buffers one 4x4 A matrix and one 4x4 B matrix, all elements 8-bit unsigned, loaded row by row. On start it clears the array, then drives the diagonally skewed row streams A0..A3 and column streams B0..B3. After the array's last accumulation it pulses done, at which point the array's r0..r15 hold C = A x B.

---
 rtl/systolic_feeder.sv | 77 +++++++
 tb/tb_systolic_feeder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one A and one B matrix and drives skewed row/column streams into a 4x4 output-stationary array
module systolic_feeder #(
  parameter int DW = 8,
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  input  logic            ld_sel,
  input  logic [1:0]      ld_row,
  input  logic [4*DW-1:0] ld_data,
  input  logic            start,
  output logic            busy,
  output logic            arr_clr,
  output logic [DW-1:0]   A0,
  output logic [DW-1:0]   A1,
  output logic [DW-1:0]   A2,
  output logic [DW-1:0]   A3,
  output logic [DW-1:0]   B0,
  output logic [DW-1:0]   B1,
  output logic [DW-1:0]   B2,
  output logic [DW-1:0]   B3,
  output logic            done
);
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;
  state_t st, ns;
  logic [3:0] t, nt;
  logic [DW-1:0] a_buf [N][N];
  logic [DW-1:0] b_buf [N][N];
  logic [DW-1:0] a_nx [N];
  logic [DW-1:0] b_nx [N];
  // next state and step counter; the counter runs on through DRAIN so t stays the array time
  always_comb begin
    ns = st == IDLE   ? (start ? CLEAR : IDLE) :
         st == CLEAR  ? STREAM :
         st == STREAM ? (t == 4'd6 ? DRAIN : STREAM) :
         st == DRAIN  ? (t == 4'd9 ? DONE : DRAIN) : IDLE;
    nt = (st == STREAM || st == DRAIN) ? t + 4'd1 : 4'd0;
  end
  // stream values for the coming cycle: lane i carries element k = t-i, zero outside the 4-wide window
  always_comb
    for (int i = 0; i < N; i++) begin
      a_nx[i] = (ns == STREAM && nt >= 4'(i) && nt - 4'(i) < 4'd4) ? a_buf[i][2'(nt - 4'(i))] : '0;
      b_nx[i] = (ns == STREAM && nt >= 4'(i) && nt - 4'(i) < 4'd4) ? b_buf[2'(nt - 4'(i))][i] : '0;
    end
  // row writes land only in IDLE, so a write coinciding with start feeds the run it starts
  always_ff @(posedge clk)
    if (!rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          a_buf[r][c] <= '0;
          b_buf[r][c] <= '0;
        end
    end else if (st == IDLE && ld_valid) begin
      for (int c = 0; c < N; c++)
        if (ld_sel) b_buf[ld_row][c] <= ld_data[DW*c +: DW];
        else a_buf[ld_row][c] <= ld_data[DW*c +: DW];
    end
  // state register with outputs registered from the next state so they line up with it
  always_ff @(posedge clk)
    if (!rst) begin
      st <= IDLE;
      t <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      arr_clr <= 1'b1;
      {A0, A1, A2, A3, B0, B1, B2, B3} <= '0;
    end else begin
      st <= ns;
      t <= nt;
      busy <= ns != IDLE;
      done <= ns == DONE;
      arr_clr <= ns == CLEAR;
      {A0, A1, A2, A3} <= {a_nx[0], a_nx[1], a_nx[2], a_nx[3]};
      {B0, B1, B2, B3} <= {b_nx[0], b_nx[1], b_nx[2], b_nx[3]};
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: drives the feeder into a behavioural 4x4 output-stationary array and scoreboards C = A x B
module tb_systolic_feeder;
  logic clk = 0, rst = 0, ld_valid = 0, ld_sel = 0, start = 0;
  logic [1:0] ld_row = 0;
  logic [31:0] ld_data = 0;
  logic busy, arr_clr, done;
  logic [7:0] A0, A1, A2, A3, B0, B1, B2, B3;
  int n_vec = 0, n_err = 0;
  logic [7:0] ma [4][4];
  logic [7:0] mb [4][4];
  logic [255:0] sb [$];
  logic [255:0] exp_c;
  logic [7:0] a_s [4];
  logic [7:0] b_s [4];
  logic [7:0] ah [4][4];
  logic [7:0] bh [4][4];
  logic [15:0] acc [4][4];

  always #5 clk = ~clk;

  systolic_feeder dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_row(ld_row), .ld_data(ld_data),
    .start(start), .busy(busy), .arr_clr(arr_clr),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3), .B0(B0), .B1(B1), .B2(B2), .B3(B3), .done(done)
  );

  always_comb begin
    a_s[0] = A0; a_s[1] = A1; a_s[2] = A2; a_s[3] = A3;
    b_s[0] = B0; b_s[1] = B1; b_s[2] = B2; b_s[3] = B3;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pa(int i, int j);
    return j == 0 ? a_s[i] : ah[i][j-1];
  endfunction

  function automatic logic [7:0] pb(int i, int j);
    return i == 0 ? b_s[j] : bh[i-1][j];
  endfunction

  // array: A moves right, B moves down, each PE accumulates its product mod 2^16
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (arr_clr) begin
          acc[i][j] <= '0;
          ah[i][j] <= '0;
          bh[i][j] <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + 16'(pa(i, j)) * 16'(pb(i, j));
          ah[i][j] <= pa(i, j);
          bh[i][j] <= pb(i, j);
        end

  function automatic logic [255:0] mul();
    logic [255:0] c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++)
          c[(4*i+j)*16 +: 16] += 16'(ma[i][k]) * 16'(mb[k][j]);
    return c;
  endfunction

  function automatic logic [7:0] skew_a(int i, int t);
    return (t >= i && t - i <= 3) ? ma[i][t-i] : 8'd0;
  endfunction

  function automatic logic [7:0] skew_b(int j, int t);
    return (t >= j && t - j <= 3) ? mb[t-j][j] : 8'd0;
  endfunction

  // scoreboard: every done pops the product expected when its run was started
  always @(negedge clk)
    if (done === 1'b1) begin
      check("done_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_c = sb.pop_front();
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            check($sformatf("r%0d", 4*i+j), acc[i][j], exp_c[(4*i+j)*16 +: 16]);
      end
    end

  task automatic load_all();
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 4; r++) begin
        ld_valid = 1;
        ld_sel = s[0];
        ld_row = 2'(r);
        for (int c = 0; c < 4; c++) ld_data[8*c +: 8] = s == 1 ? mb[r][c] : ma[r][c];
        @(posedge clk); #1;
      end
    ld_valid = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // mode 1 throws loads and starts at the DUT while it streams
  task automatic run(input int mode);
    sb.push_back(mul());
    start = 1;
    @(posedge clk); #1;
    start = 0;
    ld_valid = 0;
    for (int n = 0; n <= 11; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      check($sformatf("busy@%0d", n), busy, 1);
      check($sformatf("done@%0d", n), done, n == 11);
      check($sformatf("clr@%0d", n), arr_clr, n == 0);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("A%0d@%0d", i, n), a_s[i], (n >= 1 && n <= 7) ? skew_a(i, n - 1) : 8'd0);
        check($sformatf("B%0d@%0d", i, n), b_s[i], (n >= 1 && n <= 7) ? skew_b(i, n - 1) : 8'd0);
      end
      if (mode == 1 && n >= 2 && n <= 4) begin
        ld_valid = 1;
        ld_sel = n[0];
        ld_row = 2'($urandom_range(0, 3));
        ld_data = $urandom;
        start = 1;
      end else begin
        ld_valid = 0;
        start = 0;
      end
    end
    @(posedge clk); #1;
    check_idle("post_run");
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 8'($urandom);
        mb[i][j] = 8'($urandom);
      end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_idle("rst");
    check("rst_clr", arr_clr, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_A%0d", i), a_s[i], 0);
      check($sformatf("rst_B%0d", i), b_s[i], 0);
    end
    rst = 1;
    @(posedge clk); #1;
    check("idle_clr", arr_clr, 0);
    check_idle("idle");

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 8'(i == j);
        mb[i][j] = 8'(4*i + j + 1);
      end
    load_all();
    run(0);
    run(0);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 8'(16*i + j + 1);
        mb[i][j] = 8'd0;
      end
    load_all();
    run(0);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 8'hff;
        mb[i][j] = 8'hff;
      end
    load_all();
    run(0);

    fill_rand();
    load_all();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 0;
    @(posedge clk); #1;
    check_idle("midrst");
    check("midrst_clr", arr_clr, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("midrst_A%0d", i), a_s[i], 0);
      check($sformatf("midrst_B%0d", i), b_s[i], 0);
    end
    rst = 1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 8'd0;
        mb[i][j] = 8'd0;
      end
    @(posedge clk); #1;
    check("midrst_release_clr", arr_clr, 0);
    run(0);
    fill_rand();
    load_all();
    run(0);
    run(0);

    fill_rand();
    load_all();
    run(1);
    repeat (3) begin
      @(posedge clk); #1;
      check_idle("no_rerun");
    end

    ma[2][1] = 8'h5a;
    ld_valid = 1;
    ld_sel = 0;
    ld_row = 2'd2;
    ld_data = {ma[2][3], ma[2][2], ma[2][1], ma[2][0]};
    run(0);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
